// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and defaults for the run-sequencing controller.
//   state_t    : FSM state encoding (3 bits)
//   BASE_TBL   : default start addresses of programs 1..3
//   next_idx() : program index to use on the next arm
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DEF_A     = 10;
    localparam int DEF_CW    = 16;
    localparam int DEF_NPROG = 3;
    localparam int IDX_W     = 2;

    localparam int BASE_TBL [3] = '{0, 100, 200};

    // The very first arm after reset always selects program 0; later arms
    // step through the series and wrap after the last program.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur,
                                                  input logic started,
                                                  input int nprog);
        if (!started)
            return '0;
        if (int'(cur) >= nprog - 1)
            return '0;
        return cur + 1'b1;
    endfunction

endpackage

// File: rtl/run_ctrl_start_edge_det.sv
// start_edge_det: registers the bench Start level and flags its edges.
//   Clk   in  : clock
//   Reset in  : synchronous active-high reset (clears start_r)
//   Start in  : bench request level
//   Rise  out : Start high now, low last cycle
//   Fall  out : Start low now, high last cycle
module start_edge_det (
    input  logic Clk,
    input  logic Reset,
    input  logic Start,
    output logic Rise,
    output logic Fall
);

    logic start_r;

    always_ff @(posedge Clk) begin
        if (Reset)
            start_r <= 1'b0;
        else
            start_r <= Start;
    end

    assign Rise = Start & ~start_r;
    assign Fall = ~Start & start_r;

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: run-sequencing controller for the instruction-fetch PC.
// Arms a program on a Start rising edge, launches it on the falling edge by
// pulsing PcLoad with the program's base address, lets the PC run until a
// halt instruction or the cycle budget runs out, then freezes the PC and
// raises Done.
//
//   state | meaning
//   IDLE  | after reset, no program armed yet; PC held
//   ARMED | program selected, waiting for Start to fall; PC held
//   LOAD  | one cycle: PcLoad pulse, PC takes PcTarget
//   RUN   | PC free-running, CycleCnt counting, watching for halt/timeout
//   DONE  | program finished; PC held, Done high until next arm
//
// Ports:
//   Clk, Reset (sync, active-high), Start, HaltInstr  : inputs
//   PcLoad, PcTarget, PcHold                          : PC register controls
//   Done, Timeout, ProgIdx, CycleCnt                  : status
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int          A      = DEF_A,
    parameter int          NPROG  = DEF_NPROG,
    parameter int          BASE0  = BASE_TBL[0],
    parameter int          BASE1  = BASE_TBL[1],
    parameter int          BASE2  = BASE_TBL[2],
    parameter int          CW     = DEF_CW,
    parameter int unsigned MAXCYC = 32'h0000_FFFF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             HaltInstr,
    output logic             PcLoad,
    output logic [A-1:0]     PcTarget,
    output logic             PcHold,
    output logic             Done,
    output logic             Timeout,
    output logic [IDX_W-1:0] ProgIdx,
    output logic [CW-1:0]    CycleCnt
);

    localparam logic [CW-1:0] CNT_MAX  = CW'(MAXCYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAXCYC - 1);

    state_t state;
    logic   started;
    logic   rise;
    logic   fall;

    // Any index past the third program reuses the last base address.
    function automatic logic [A-1:0] base_of(input logic [IDX_W-1:0] idx);
        case (idx)
            2'd0:    return A'(BASE0);
            2'd1:    return A'(BASE1);
            default: return A'(BASE2);
        endcase
    endfunction

    start_edge_det u_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Rise  (rise),
        .Fall  (fall)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            started  <= 1'b0;
            PcLoad   <= 1'b0;
            PcTarget <= '0;
            PcHold   <= 1'b1;
            Done     <= 1'b0;
            Timeout  <= 1'b0;
            ProgIdx  <= '0;
            CycleCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    PcHold <= 1'b1;
                    if (rise) begin
                        state   <= ARMED;
                        ProgIdx <= next_idx(ProgIdx, started, NPROG);
                        started <= 1'b1;
                    end
                end
                ARMED: begin
                    PcHold <= 1'b1;
                    if (fall) begin
                        state    <= LOAD;
                        PcTarget <= base_of(ProgIdx);
                        PcLoad   <= 1'b1;
                        PcHold   <= 1'b0;
                        CycleCnt <= '0;
                    end
                end
                LOAD: begin
                    state  <= RUN;
                    PcLoad <= 1'b0;
                    PcHold <= 1'b0;
                end
                RUN: begin
                    PcHold <= 1'b0;
                    if (CycleCnt != CNT_MAX)
                        CycleCnt <= CycleCnt + 1'b1;
                    // Halt takes precedence over a budget expiring in the same cycle.
                    if (HaltInstr) begin
                        state   <= DONE;
                        Done    <= 1'b1;
                        Timeout <= 1'b0;
                        PcHold  <= 1'b1;
                    end else if (CycleCnt == CNT_LAST) begin
                        state   <= DONE;
                        Done    <= 1'b1;
                        Timeout <= 1'b1;
                        PcHold  <= 1'b1;
                    end
                end
                DONE: begin
                    PcHold <= 1'b1;
                    if (rise) begin
                        state   <= ARMED;
                        Done    <= 1'b0;
                        Timeout <= 1'b0;
                        ProgIdx <= next_idx(ProgIdx, started, NPROG);
                        started <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    PcHold <= 1'b1;
                end
            endcase
        end
    end

endmodule
